// File: rtl/button_input_capture_if.sv
// Player-button bundle between the button front end and the game controller.
// The controller side drives the raw levels and enable; the front end returns the accepted press.
interface button_input_capture_if;
   logic [3:0] btn_raw;
   logic       enable;
   logic [3:0] user_input;
   logic       input_valid;
   logic       multi_press_err;
   logic [3:0] btn_held;

   modport master (
      output btn_raw,
      output enable,
      input  user_input,
      input  input_valid,
      input  multi_press_err,
      input  btn_held
   );

   modport slave (
      input  btn_raw,
      input  enable,
      output user_input,
      output input_valid,
      output multi_press_err,
      output btn_held
   );
endinterface

// File: rtl/button_input_capture.sv
// Synchronizes and debounces the four Simon Says buttons and turns a clean
// single-button press into a one-cycle accept strobe, or a reject strobe for chords.
module button_input_capture #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 16
) (
   input logic                   clk,
   input logic                   rst,
   button_input_capture_if.slave bus
);

   typedef enum logic {
      IDLE,
      WAIT_RELEASE
   } state_e;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [3:0]       sync1_q, sync2_q;
   logic [3:0]       stable_q, stable_d;
   logic [3:0]       stableDly_q;
   logic [CNT_W-1:0] cnt_q [4];
   logic [CNT_W-1:0] cnt_d [4];
   logic [1:0]       warm_q, warm_d;
   state_e           state_q, state_d;
   logic [3:0]       userInput_q, userInput_d;
   logic             inputValid_q, inputValid_d;
   logic             multiErr_q, multiErr_d;

   logic [3:0]       rise;
   logic             singleRise;
   logic             noOtherHeld;
   logic             releaseSeen;

   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < 4; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               stable_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   assign rise        = stable_q & ~stableDly_q;
   assign singleRise  = (rise != 4'd0) && ((rise & (rise - 4'd1)) == 4'd0);
   assign noOtherHeld = (stable_q & ~rise) == 4'd0;

   // The sync flops are cleared by reset, so "released" only counts once the
   // pipeline has refilled with real samples; a button held through reset stays blocked.
   assign warm_d      = (warm_q == 2'd2) ? warm_q : warm_q + 2'd1;
   assign releaseSeen = (warm_q == 2'd2) && (stable_q == 4'd0) &&
                        (sync1_q == 4'd0) && (sync2_q == 4'd0);

   always_comb begin
      state_d      = state_q;
      userInput_d  = userInput_q;
      inputValid_d = 1'b0;
      multiErr_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (!bus.enable) begin
               state_d = WAIT_RELEASE;
            end else if (singleRise && noOtherHeld) begin
               userInput_d  = rise;
               inputValid_d = 1'b1;
               state_d      = WAIT_RELEASE;
            end else if (rise != 4'd0) begin
               multiErr_d = 1'b1;
               state_d    = WAIT_RELEASE;
            end
         end
         WAIT_RELEASE: begin
            if (releaseSeen && bus.enable) begin
               state_d = IDLE;
            end
         end
         default: state_d = WAIT_RELEASE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         stable_q     <= '0;
         stableDly_q  <= '0;
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= '0;
         end
         warm_q       <= '0;
         state_q      <= WAIT_RELEASE;
         userInput_q  <= '0;
         inputValid_q <= 1'b0;
         multiErr_q   <= 1'b0;
      end else begin
         sync1_q      <= bus.btn_raw;
         sync2_q      <= sync1_q;
         stable_q     <= stable_d;
         stableDly_q  <= stable_q;
         for (int i = 0; i < 4; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         warm_q       <= warm_d;
         state_q      <= state_d;
         userInput_q  <= userInput_d;
         inputValid_q <= inputValid_d;
         multiErr_q   <= multiErr_d;
      end
   end

   assign bus.user_input      = userInput_q;
   assign bus.input_valid     = inputValid_q;
   assign bus.multi_press_err = multiErr_q;
   assign bus.btn_held        = stable_q;

endmodule

// File: tb/tb_button_input_capture.sv
// Directed bench for button_input_capture with a short debounce window.
// A posedge monitor counts strobes; the stimulus thread drives and checks on negedges.
module tb_button_input_capture;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   int   edgeCnt;
   int   validCount;
   int   errCount;
   int   validEdge;
   logic [3:0] heldMask;

   button_input_capture_if bus();

   button_input_capture #(
      .DEBOUNCE_CYCLES(4),
      .CNT_W(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Strobe monitor, sampled just after each rising edge.
   always begin
      @(posedge clk);
      #1;
      edgeCnt++;
      if (bus.input_valid) begin
         validCount++;
         validEdge = edgeCnt;
      end
      if (bus.multi_press_err) errCount++;
      heldMask = heldMask | bus.btn_held;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] raw, input logic en, input int cycles);
      bus.btn_raw = raw;
      bus.enable  = en;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic clearCounters();
      edgeCnt    = 0;
      validCount = 0;
      errCount   = 0;
      validEdge  = 0;
      heldMask   = 4'd0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      clearCounters();
      rst         = 1'b1;
      bus.btn_raw = 4'd0;
      bus.enable  = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset user_input", 32'(bus.user_input), 32'h0);
      checkOutput("reset input_valid", 32'(bus.input_valid), 32'h0);
      checkOutput("reset multi_err", 32'(bus.multi_press_err), 32'h0);
      checkOutput("reset btn_held", 32'(bus.btn_held), 32'h0);
      rst = 1'b0;

      // 1: clean single press, latency and hold behaviour
      applyStimulus(4'b0000, 1'b1, 10);
      clearCounters();
      applyStimulus(4'b0010, 1'b1, 20);
      checkOutput("t1 valid count", 32'(validCount), 32'd1);
      checkOutput("t1 valid edge", 32'(validEdge), 32'd7);
      checkOutput("t1 user_input", 32'(bus.user_input), 32'h2);
      checkOutput("t1 btn_held", 32'(bus.btn_held), 32'h2);
      checkOutput("t1 err count", 32'(errCount), 32'd0);
      applyStimulus(4'b0000, 1'b1, 15);
      checkOutput("t1 release user_input", 32'(bus.user_input), 32'h2);
      checkOutput("t1 release btn_held", 32'(bus.btn_held), 32'h0);
      checkOutput("t1 release valid count", 32'(validCount), 32'd1);

      // 2: short glitch is filtered
      clearCounters();
      applyStimulus(4'b0001, 1'b1, 3);
      applyStimulus(4'b0000, 1'b1, 12);
      checkOutput("t2 held ever", 32'(heldMask), 32'h0);
      checkOutput("t2 valid count", 32'(validCount), 32'd0);
      checkOutput("t2 err count", 32'(errCount), 32'd0);

      // 3: chord rejected, then a clean press accepted
      clearCounters();
      applyStimulus(4'b0101, 1'b1, 15);
      checkOutput("t3 err count", 32'(errCount), 32'd1);
      checkOutput("t3 valid count", 32'(validCount), 32'd0);
      checkOutput("t3 user_input kept", 32'(bus.user_input), 32'h2);
      applyStimulus(4'b0000, 1'b1, 15);
      applyStimulus(4'b0100, 1'b1, 15);
      checkOutput("t3 valid after chord", 32'(validCount), 32'd1);
      checkOutput("t3 user_input", 32'(bus.user_input), 32'h4);
      checkOutput("t3 err count after", 32'(errCount), 32'd1);

      // 4: second button added while first held is ignored
      applyStimulus(4'b0000, 1'b1, 15);
      clearCounters();
      applyStimulus(4'b1000, 1'b1, 15);
      checkOutput("t4 first valid", 32'(validCount), 32'd1);
      checkOutput("t4 first user_input", 32'(bus.user_input), 32'h8);
      applyStimulus(4'b1001, 1'b1, 15);
      checkOutput("t4 added valid", 32'(validCount), 32'd1);
      checkOutput("t4 added err", 32'(errCount), 32'd0);
      checkOutput("t4 added btn_held", 32'(bus.btn_held), 32'h9);
      applyStimulus(4'b0000, 1'b1, 15);
      applyStimulus(4'b0001, 1'b1, 15);
      checkOutput("t4 second valid", 32'(validCount), 32'd2);
      checkOutput("t4 second user_input", 32'(bus.user_input), 32'h1);

      // 5: press made while disabled is never accepted
      applyStimulus(4'b0000, 1'b1, 15);
      clearCounters();
      applyStimulus(4'b0010, 1'b0, 15);
      applyStimulus(4'b0010, 1'b1, 15);
      checkOutput("t5 disabled valid", 32'(validCount), 32'd0);
      checkOutput("t5 disabled err", 32'(errCount), 32'd0);
      checkOutput("t5 disabled user_input", 32'(bus.user_input), 32'h1);
      applyStimulus(4'b0000, 1'b1, 15);
      applyStimulus(4'b0010, 1'b1, 15);
      checkOutput("t5 repress valid", 32'(validCount), 32'd1);
      checkOutput("t5 repress user_input", 32'(bus.user_input), 32'h2);

      // 6: reset in mid-debounce with the button held
      applyStimulus(4'b0000, 1'b1, 15);
      clearCounters();
      applyStimulus(4'b0100, 1'b1, 4);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("t6 in reset user_input", 32'(bus.user_input), 32'h0);
      rst = 1'b0;
      validCount = 0;
      errCount   = 0;
      applyStimulus(4'b0100, 1'b1, 20);
      checkOutput("t6 held valid", 32'(validCount), 32'd0);
      checkOutput("t6 held err", 32'(errCount), 32'd0);
      checkOutput("t6 held btn_held", 32'(bus.btn_held), 32'h4);
      applyStimulus(4'b0000, 1'b1, 15);
      clearCounters();
      applyStimulus(4'b0100, 1'b1, 15);
      checkOutput("t6 repress valid", 32'(validCount), 32'd1);
      checkOutput("t6 repress edge", 32'(validEdge), 32'd7);
      checkOutput("t6 repress user_input", 32'(bus.user_input), 32'h4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
